fc_layer_stream: RTL and testbench

- Fully-connected classifier stage directly downstream of the max-pooling stage.
- Consumes one pooled pixel vector (all CH channels) per valid beat and accumulates CH×N_OUT signed MACs in parallel, so upstream never sees backpressure.
- After N_PIX beats it emits all N_OUT class scores (accumulator plus bias), then a sequential argmax of the winning class.
- Weights and biases are loaded through a simple write port.

---
 rtl/fc_layer_stream_pkg.sv | 26 ++
 rtl/fc_argmax_scan.sv | 74 +++++++
 rtl/fc_layer_stream.sv | 124 ++++++++++++
 tb/tb_fc_layer_stream.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_stream_pkg.sv
`default_nettype none
// ==========================================================================
// fc_layer_stream_pkg : stage-4 defaults and shared types for the FC stage
// Rev 1.0
// ==========================================================================
package fc_layer_stream_pkg;
  localparam int FC_CH        = 3;
  localparam int FC_IN_BW     = 32;
  localparam int FC_W_BW      = 8;
  localparam int FC_N_PIX     = 16;
  localparam int FC_N_OUT     = 4;
  localparam int FC_ACC_BW    = 48;
  localparam int FC_BIAS_BASE = FC_N_PIX * FC_N_OUT * FC_CH;

  typedef enum logic [0:0] {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

  // Flat weight address of w[pix][out][ch]
  function automatic int fc_w_index(input int pix, input int out, input int ch,
                                    input int n_out, input int n_ch);
    return (pix * n_out + out) * n_ch + ch;
  endfunction
endpackage
`default_nettype wire

// File: rtl/fc_argmax_scan.sv
`default_nettype none
// ==========================================================================
// fc_argmax_scan : sequential argmax over a registered score snapshot
// Rev 1.0
// ==========================================================================
module fc_argmax_scan
  import fc_layer_stream_pkg::*;
#(
  parameter int N_OUT  = FC_N_OUT,
  parameter int ACC_BW = FC_ACC_BW
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_soft_clr,
  input  logic                      i_snap,
  input  logic [N_OUT*ACC_BW-1:0]   i_scores,
  output logic                      o_class_valid,
  output logic [$clog2(N_OUT)-1:0]  o_class,
  output logic                      o_overrun
);
  localparam int CLS_BW = $clog2(N_OUT);
  localparam logic [CLS_BW-1:0] LAST_IDX = CLS_BW'(N_OUT - 1);

  scan_state_e              state_q;
  logic [CLS_BW-1:0]        idx_q;
  logic [CLS_BW-1:0]        best_q;
  logic [CLS_BW-1:0]        class_q;
  logic                     class_valid_q;
  logic                     overrun_q;
  logic signed [ACC_BW-1:0] cand_score;
  logic signed [ACC_BW-1:0] best_score;
  logic [CLS_BW-1:0]        win_idx;

  // Scores are held stable by the top between snapshots, so they are read in place
  assign cand_score = i_scores[int'(idx_q)*ACC_BW +: ACC_BW];
  assign best_score = i_scores[int'(best_q)*ACC_BW +: ACC_BW];
  assign win_idx    = (cand_score > best_score) ? idx_q : best_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SCAN_IDLE;
      idx_q         <= '0;
      best_q        <= '0;
      class_q       <= '0;
      class_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      if (i_soft_clr) begin
        state_q   <= SCAN_IDLE;
        overrun_q <= 1'b0;
      end else if (i_snap) begin
        if (state_q == SCAN_RUN) overrun_q <= 1'b1;
        best_q  <= '0;
        idx_q   <= CLS_BW'(1);
        state_q <= SCAN_RUN;
      end else if (state_q == SCAN_RUN) begin
        best_q <= win_idx;
        if (idx_q == LAST_IDX) begin
          class_q       <= win_idx;
          class_valid_q <= 1'b1;
          state_q       <= SCAN_IDLE;
        end else begin
          idx_q <= idx_q + CLS_BW'(1);
        end
      end
    end
  end

  assign o_class_valid = class_valid_q;
  assign o_class       = class_q;
  assign o_overrun     = overrun_q;
endmodule
`default_nettype wire

// File: rtl/fc_layer_stream.sv
`default_nettype none
// ==========================================================================
// fc_layer_stream : streaming fully-connected classifier with argmax
// Rev 1.0
// ==========================================================================
module fc_layer_stream
  import fc_layer_stream_pkg::*;
#(
  parameter int CH     = FC_CH,
  parameter int IN_BW  = FC_IN_BW,
  parameter int W_BW   = FC_W_BW,
  parameter int N_PIX  = FC_N_PIX,
  parameter int N_OUT  = FC_N_OUT,
  parameter int ACC_BW = FC_ACC_BW,
  parameter int WA_BW  = $clog2(N_PIX*N_OUT*CH + N_OUT)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_soft_clr,
  input  logic                      i_pool_valid,
  input  logic [CH*IN_BW-1:0]       i_pool,
  input  logic                      i_w_we,
  input  logic [WA_BW-1:0]          i_w_addr,
  input  logic [W_BW-1:0]           i_w_data,
  output logic                      o_score_valid,
  output logic [N_OUT*ACC_BW-1:0]   o_scores,
  output logic                      o_class_valid,
  output logic [$clog2(N_OUT)-1:0]  o_class,
  output logic                      o_overrun
);
  localparam int N_W   = N_PIX * N_OUT * CH;
  localparam int WI_BW = $clog2(N_W);
  localparam int PC_BW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int P_BW  = IN_BW + W_BW;

  logic signed [W_BW-1:0]   w_q     [N_W];
  logic signed [W_BW-1:0]   b_q     [N_OUT];
  logic signed [ACC_BW-1:0] acc_q   [N_OUT];
  logic signed [ACC_BW-1:0] acc_d   [N_OUT];
  logic signed [ACC_BW-1:0] score_d [N_OUT];
  logic [PC_BW-1:0]         pix_cnt_q;
  logic [N_OUT*ACC_BW-1:0]  scores_q;
  logic                     score_valid_q;

  logic signed [IN_BW-1:0]  pool_ch;
  logic signed [P_BW-1:0]   prod;
  logic [WI_BW-1:0]         widx;
  logic                     last_beat;
  logic                     snap;

  // All N_OUT x CH products of the current pixel are formed in one cycle
  always_comb begin
    pool_ch = '0;
    prod    = '0;
    widx    = '0;
    for (int o = 0; o < N_OUT; o++) begin
      acc_d[o] = acc_q[o];
      for (int c = 0; c < CH; c++) begin
        pool_ch  = i_pool[c*IN_BW +: IN_BW];
        widx     = WI_BW'(fc_w_index(int'(pix_cnt_q), o, c, N_OUT, CH));
        prod     = P_BW'(pool_ch) * P_BW'(w_q[widx]);
        acc_d[o] = acc_d[o] + ACC_BW'(prod);
      end
      score_d[o] = acc_d[o] + ACC_BW'(b_q[o]);
    end
  end

  assign last_beat = (pix_cnt_q == PC_BW'(N_PIX - 1));
  assign snap      = i_pool_valid && last_beat && !i_soft_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < N_W; a++) w_q[a] <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        b_q[o]   <= '0;
        acc_q[o] <= '0;
      end
      pix_cnt_q     <= '0;
      scores_q      <= '0;
      score_valid_q <= 1'b0;
    end else begin
      score_valid_q <= 1'b0;
      for (int a = 0; a < N_W; a++)
        if (i_w_we && int'(i_w_addr) == a) w_q[a] <= i_w_data;
      for (int o = 0; o < N_OUT; o++)
        if (i_w_we && int'(i_w_addr) == N_W + o) b_q[o] <= i_w_data;

      if (i_soft_clr) begin
        for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
        pix_cnt_q <= '0;
      end else if (i_pool_valid) begin
        if (last_beat) begin
          for (int o = 0; o < N_OUT; o++) begin
            acc_q[o]                      <= '0;
            scores_q[o*ACC_BW +: ACC_BW] <= score_d[o];
          end
          pix_cnt_q     <= '0;
          score_valid_q <= 1'b1;
        end else begin
          for (int o = 0; o < N_OUT; o++) acc_q[o] <= acc_d[o];
          pix_cnt_q <= pix_cnt_q + PC_BW'(1);
        end
      end
    end
  end

  fc_argmax_scan #(
    .N_OUT  (N_OUT),
    .ACC_BW (ACC_BW)
  ) u_argmax (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_soft_clr    (i_soft_clr),
    .i_snap        (snap),
    .i_scores      (scores_q),
    .o_class_valid (o_class_valid),
    .o_class       (o_class),
    .o_overrun     (o_overrun)
  );

  assign o_score_valid = score_valid_q;
  assign o_scores      = scores_q;
endmodule
`default_nettype wire

// File: tb/tb_fc_layer_stream.sv
`default_nettype none
// ==========================================================================
// tb_fc_layer_stream : self-checking bench for fc_layer_stream
// Rev 1.0
// ==========================================================================
module tb_fc_layer_stream;
  localparam int CH = 3, IN_BW = 32, W_BW = 8, N_PIX = 16, N_OUT = 4, ACC_BW = 48;
  localparam int N_W = N_PIX * N_OUT * CH;
  localparam int WA_BW = 8, WA2_BW = 5;
  localparam int PW = CH * IN_BW, SW = N_OUT * ACC_BW;

  typedef struct {
    bit v; bit clr; bit we; int addr; int data; logic [PW-1:0] pool;
  } beat_t;
  typedef logic [SW+31:0] sev_t;
  typedef logic [33:0]    cev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             soft_clr = 0, pool_valid = 0, w_we = 0;
  logic [PW-1:0]    pool = '0;
  logic [WA_BW-1:0] w_addr = '0;
  logic [W_BW-1:0]  w_data = '0;
  logic             score_valid, class_valid, overrun;
  logic [SW-1:0]    scores;
  logic [1:0]       cls;

  logic              d2_soft_clr = 0, d2_pool_valid = 0, d2_w_we = 0;
  logic [PW-1:0]     d2_pool = '0;
  logic [WA2_BW-1:0] d2_w_addr = '0;
  logic [W_BW-1:0]   d2_w_data = '0;
  logic              d2_score_valid, d2_class_valid, d2_overrun;
  logic [SW-1:0]     d2_scores;
  logic [1:0]        d2_cls;

  fc_layer_stream dut (
    .clk(clk), .reset_n(reset_n), .i_soft_clr(soft_clr), .i_pool_valid(pool_valid),
    .i_pool(pool), .i_w_we(w_we), .i_w_addr(w_addr), .i_w_data(w_data),
    .o_score_valid(score_valid), .o_scores(scores), .o_class_valid(class_valid),
    .o_class(cls), .o_overrun(overrun)
  );

  fc_layer_stream #(.N_PIX(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_soft_clr(d2_soft_clr), .i_pool_valid(d2_pool_valid),
    .i_pool(d2_pool), .i_w_we(d2_w_we), .i_w_addr(d2_w_addr), .i_w_data(d2_w_data),
    .o_score_valid(d2_score_valid), .o_scores(d2_scores), .o_class_valid(d2_class_valid),
    .o_class(d2_cls), .o_overrun(d2_overrun)
  );

  int n_tests = 0, n_fail = 0;
  beat_t stim[$];
  sev_t  e_sc[$], a_sc[$];
  cev_t  e_cl[$], a_cl[$];
  int    m_w[N_W];
  int    m_b[N_OUT];

  function automatic logic [PW-1:0] px(input int a, input int b, input int c);
    return {32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [PW-1:0] rand_pool();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push(input bit v, input logic [PW-1:0] p, input bit clr,
                      input bit we, input int addr, input int data);
    beat_t b;
    b.v = v; b.pool = p; b.clr = clr; b.we = we; b.addr = addr; b.data = data;
    stim.push_back(b);
  endtask

  task automatic load_weights(input int wv[N_OUT], input int bv[N_OUT]);
    for (int a = 0; a < N_W; a++) push(0, '0, 0, 1, a, wv[(a / CH) % N_OUT]);
    for (int o = 0; o < N_OUT; o++) push(0, '0, 0, 1, N_W + o, bv[o]);
  endtask

  // Reference: per image, score[o] = bias[o] + sum over pixels and channels of x*w
  task automatic model_stream();
    logic signed [ACC_BW-1:0] acc [N_OUT];
    logic signed [ACC_BW-1:0] sc  [N_OUT];
    logic [SW-1:0]            flat;
    logic [PW-1:0]            pv;
    logic signed [IN_BW-1:0]  chv;
    int pix, due, pcls, best;
    bit pend;
    pix = 0; due = 0; pcls = 0; pend = 0;
    e_sc.delete(); e_cl.delete();
    for (int o = 0; o < N_OUT; o++) acc[o] = '0;
    for (int i = 0; i < stim.size(); i++) begin
      if (stim[i].clr) begin
        for (int o = 0; o < N_OUT; o++) acc[o] = '0;
        pix = 0; pend = 0;
      end else if (stim[i].v) begin
        pv = stim[i].pool;
        for (int o = 0; o < N_OUT; o++)
          for (int c = 0; c < CH; c++) begin
            chv = pv[c*IN_BW +: IN_BW];
            acc[o] += ACC_BW'(longint'(chv) * longint'(m_w[(pix * N_OUT + o) * CH + c]));
          end
        pix++;
        if (pix == N_PIX) begin
          best = 0;
          for (int o = 0; o < N_OUT; o++) begin
            sc[o] = acc[o] + ACC_BW'(longint'(m_b[o]));
            flat[o*ACC_BW +: ACC_BW] = sc[o];
          end
          for (int o = 1; o < N_OUT; o++) if (sc[o] > sc[best]) best = o;
          e_sc.push_back({32'(i), flat});
          pend = 1; due = i + N_OUT - 1; pcls = best; pix = 0;
          for (int o = 0; o < N_OUT; o++) acc[o] = '0;
        end
      end
      if (pend && due == i) begin
        e_cl.push_back({32'(i), 2'(pcls)});
        pend = 0;
      end
      if (stim[i].we) begin
        if (stim[i].addr < N_W) m_w[stim[i].addr] = stim[i].data;
        else if (stim[i].addr < N_W + N_OUT) m_b[stim[i].addr - N_W] = stim[i].data;
      end
    end
  endtask

  task automatic exec_stream();
    repeat (6) push(0, '0, 0, 0, 0, 0);
    model_stream();
    a_sc.delete(); a_cl.delete();
    for (int i = 0; i < stim.size(); i++) begin
      pool_valid = stim[i].v; pool = stim[i].pool; soft_clr = stim[i].clr;
      w_we = stim[i].we; w_addr = WA_BW'(stim[i].addr); w_data = W_BW'(stim[i].data);
      @(posedge clk); #1;
      if (score_valid) a_sc.push_back({32'(i), scores});
      if (class_valid) a_cl.push_back({32'(i), cls});
    end
    pool_valid = 0; pool = '0; soft_clr = 0; w_we = 0; w_addr = '0; w_data = '0;
    stim.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (score_valid !== 1'b0) begin n_fail++; $display("FAIL rst_score_valid: got %b want 0", score_valid); end
    n_tests++; if (scores !== '0) begin n_fail++; $display("FAIL rst_scores: got %h want 0", scores); end
    n_tests++; if (class_valid !== 1'b0) begin n_fail++; $display("FAIL rst_class_valid: got %b want 0", class_valid); end
    n_tests++; if (cls !== 2'd0) begin n_fail++; $display("FAIL rst_class: got %0d want 0", cls); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_tests++; if (d2_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun2: got %b want 0", d2_overrun); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    int wv[N_OUT] = '{1, 1, 1, 1};
    int bv[N_OUT] = '{0, 0, 0, 0};
    load_weights(wv, bv);
    for (int p = 0; p < N_PIX; p++) push(1, px(1, 2, 3), 0, 0, 0, 0);
    exec_stream();
    n_tests++; if (a_sc.size() != e_sc.size()) begin n_fail++; $display("FAIL ones_score_count: got %0d want %0d", a_sc.size(), e_sc.size()); end
    foreach (e_sc[i]) begin
      n_tests++; if (i >= a_sc.size() || a_sc[i] !== e_sc[i]) begin n_fail++; $display("FAIL ones_score_evt%0d: got %h want %h", i, (i < a_sc.size()) ? a_sc[i] : '0, e_sc[i]); end
    end
    n_tests++; if (a_cl.size() != e_cl.size()) begin n_fail++; $display("FAIL ones_class_count: got %0d want %0d", a_cl.size(), e_cl.size()); end
    foreach (e_cl[i]) begin
      n_tests++; if (i >= a_cl.size() || a_cl[i] !== e_cl[i]) begin n_fail++; $display("FAIL ones_class_evt%0d: got %h want %h", i, (i < a_cl.size()) ? a_cl[i] : '0, e_cl[i]); end
    end
    n_tests++; if (scores !== {4{48'd96}}) begin n_fail++; $display("FAIL ones_scores_const: got %h want all 96", scores); end
    n_tests++; if (cls !== 2'd0) begin n_fail++; $display("FAIL ones_class_const: got %0d want 0", cls); end
  endtask

  task automatic test_out2_double();
    int wv[N_OUT] = '{1, 1, 2, 1};
    int bv[N_OUT] = '{0, 0, 0, 0};
    load_weights(wv, bv);
    for (int p = 0; p < N_PIX; p++) push(1, px(1, 2, 3), 0, 0, 0, 0);
    exec_stream();
    n_tests++; if (a_sc.size() != e_sc.size()) begin n_fail++; $display("FAIL dbl_score_count: got %0d want %0d", a_sc.size(), e_sc.size()); end
    foreach (e_sc[i]) begin
      n_tests++; if (i >= a_sc.size() || a_sc[i] !== e_sc[i]) begin n_fail++; $display("FAIL dbl_score_evt%0d: got %h want %h", i, (i < a_sc.size()) ? a_sc[i] : '0, e_sc[i]); end
    end
    n_tests++; if (a_cl.size() != e_cl.size()) begin n_fail++; $display("FAIL dbl_class_count: got %0d want %0d", a_cl.size(), e_cl.size()); end
    foreach (e_cl[i]) begin
      n_tests++; if (i >= a_cl.size() || a_cl[i] !== e_cl[i]) begin n_fail++; $display("FAIL dbl_class_evt%0d: got %h want %h", i, (i < a_cl.size()) ? a_cl[i] : '0, e_cl[i]); end
    end
    n_tests++; if (scores !== {48'd96, 48'd192, 48'd96, 48'd96}) begin n_fail++; $display("FAIL dbl_scores_const: got %h want 96/192/96/96", scores); end
    n_tests++; if (cls !== 2'd2) begin n_fail++; $display("FAIL dbl_class_const: got %0d want 2", cls); end
  endtask

  task automatic test_negative();
    int wv[N_OUT] = '{0, -1, 0, 0};
    int bv[N_OUT] = '{0, -5, 0, 0};
    load_weights(wv, bv);
    for (int p = 0; p < N_PIX; p++) push(1, px(5, 5, 5), 0, 0, 0, 0);
    exec_stream();
    n_tests++; if (a_sc.size() != e_sc.size()) begin n_fail++; $display("FAIL neg_score_count: got %0d want %0d", a_sc.size(), e_sc.size()); end
    foreach (e_sc[i]) begin
      n_tests++; if (i >= a_sc.size() || a_sc[i] !== e_sc[i]) begin n_fail++; $display("FAIL neg_score_evt%0d: got %h want %h", i, (i < a_sc.size()) ? a_sc[i] : '0, e_sc[i]); end
    end
    n_tests++; if (a_cl.size() != e_cl.size()) begin n_fail++; $display("FAIL neg_class_count: got %0d want %0d", a_cl.size(), e_cl.size()); end
    foreach (e_cl[i]) begin
      n_tests++; if (i >= a_cl.size() || a_cl[i] !== e_cl[i]) begin n_fail++; $display("FAIL neg_class_evt%0d: got %h want %h", i, (i < a_cl.size()) ? a_cl[i] : '0, e_cl[i]); end
    end
    n_tests++; if (scores !== {48'd0, 48'd0, 48'(-245), 48'd0}) begin n_fail++; $display("FAIL neg_scores_const: got %h want 0/0/-245/0", scores); end
    n_tests++; if (cls !== 2'd0) begin n_fail++; $display("FAIL neg_class_const: got %0d want 0", cls); end
  endtask

  task automatic test_back_to_back();
    int wv[N_OUT] = '{1, 1, 1, 1};
    int bv[N_OUT] = '{0, 0, 0, 0};
    int gap;
    load_weights(wv, bv);
    for (int p = 0; p < 2 * N_PIX; p++) push(1, px(1, 2, 3), 0, p == N_PIX, N_W + 3, 1);
    exec_stream();
    n_tests++; if (a_sc.size() != e_sc.size()) begin n_fail++; $display("FAIL b2b_score_count: got %0d want %0d", a_sc.size(), e_sc.size()); end
    foreach (e_sc[i]) begin
      n_tests++; if (i >= a_sc.size() || a_sc[i] !== e_sc[i]) begin n_fail++; $display("FAIL b2b_score_evt%0d: got %h want %h", i, (i < a_sc.size()) ? a_sc[i] : '0, e_sc[i]); end
    end
    n_tests++; if (a_cl.size() != e_cl.size()) begin n_fail++; $display("FAIL b2b_class_count: got %0d want %0d", a_cl.size(), e_cl.size()); end
    foreach (e_cl[i]) begin
      n_tests++; if (i >= a_cl.size() || a_cl[i] !== e_cl[i]) begin n_fail++; $display("FAIL b2b_class_evt%0d: got %h want %h", i, (i < a_cl.size()) ? a_cl[i] : '0, e_cl[i]); end
    end
    gap = (a_sc.size() == 2) ? int'(a_sc[1][SW+31:SW]) - int'(a_sc[0][SW+31:SW]) : -1;
    n_tests++; if (gap != N_PIX) begin n_fail++; $display("FAIL b2b_pulse_gap: got %0d want %0d", gap, N_PIX); end
    n_tests++; if (scores !== {48'd97, 48'd96, 48'd96, 48'd96}) begin n_fail++; $display("FAIL b2b_scores_const: got %h want 97/96/96/96", scores); end
    n_tests++; if (cls !== 2'd3) begin n_fail++; $display("FAIL b2b_class_const: got %0d want 3", cls); end
  endtask

  task automatic test_soft_clr();
    int wv[N_OUT] = '{1, 1, 1, 1};
    int bv[N_OUT] = '{0, 0, 0, 0};
    load_weights(wv, bv);
    for (int p = 0; p < 7; p++) push(1, rand_pool(), 0, 0, 0, 0);
    push(0, '0, 1, 0, 0, 0);
    for (int p = 0; p < N_PIX; p++) push(1, px(1, 1, 1), 0, 0, 0, 0);
    for (int p = 0; p < 5; p++) push(1, rand_pool(), 0, 0, 0, 0);
    push(1, rand_pool(), 1, 0, 0, 0);
    for (int p = 0; p < N_PIX; p++) push(1, px(1, 1, 1), 0, 0, 0, 0);
    exec_stream();
    n_tests++; if (a_sc.size() != e_sc.size()) begin n_fail++; $display("FAIL clr_score_count: got %0d want %0d", a_sc.size(), e_sc.size()); end
    foreach (e_sc[i]) begin
      n_tests++; if (i >= a_sc.size() || a_sc[i] !== e_sc[i]) begin n_fail++; $display("FAIL clr_score_evt%0d: got %h want %h", i, (i < a_sc.size()) ? a_sc[i] : '0, e_sc[i]); end
    end
    n_tests++; if (a_cl.size() != e_cl.size()) begin n_fail++; $display("FAIL clr_class_count: got %0d want %0d", a_cl.size(), e_cl.size()); end
    foreach (e_cl[i]) begin
      n_tests++; if (i >= a_cl.size() || a_cl[i] !== e_cl[i]) begin n_fail++; $display("FAIL clr_class_evt%0d: got %h want %h", i, (i < a_cl.size()) ? a_cl[i] : '0, e_cl[i]); end
    end
    n_tests++; if (scores !== {4{48'd48}}) begin n_fail++; $display("FAIL clr_scores_const: got %h want all 48", scores); end
  endtask

  task automatic test_random();
    for (int a = 0; a < N_W + N_OUT; a++) push(0, '0, 0, 1, a, int'($urandom_range(0, 255)) - 128);
    for (int img = 0; img < 3; img++)
      for (int p = 0; p < N_PIX; p++) begin
        push(1, rand_pool(), 0, 0, 0, 0);
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) push(0, rand_pool(), 0, 0, 0, 0);
      end
    exec_stream();
    n_tests++; if (a_sc.size() != e_sc.size()) begin n_fail++; $display("FAIL rnd_score_count: got %0d want %0d", a_sc.size(), e_sc.size()); end
    foreach (e_sc[i]) begin
      n_tests++; if (i >= a_sc.size() || a_sc[i] !== e_sc[i]) begin n_fail++; $display("FAIL rnd_score_evt%0d: got %h want %h", i, (i < a_sc.size()) ? a_sc[i] : '0, e_sc[i]); end
    end
    n_tests++; if (a_cl.size() != e_cl.size()) begin n_fail++; $display("FAIL rnd_class_count: got %0d want %0d", a_cl.size(), e_cl.size()); end
    foreach (e_cl[i]) begin
      n_tests++; if (i >= a_cl.size() || a_cl[i] !== e_cl[i]) begin n_fail++; $display("FAIL rnd_class_evt%0d: got %h want %h", i, (i < a_cl.size()) ? a_cl[i] : '0, e_cl[i]); end
    end
  endtask

  // Two-pixel instance: second snapshot arrives while the first scan is running
  task automatic test_overrun();
    logic [PW-1:0] seq [4];
    int n_cls, cls_cyc;
    logic [1:0] cls_val;
    n_cls = 0; cls_cyc = -1; cls_val = '0;
    seq[0] = px(-5, 0, 0); seq[1] = px(0, 0, 0); seq[2] = px(7, 0, 0); seq[3] = px(0, 0, 0);
    d2_w_we = 1; d2_w_addr = WA2_BW'(3); d2_w_data = 8'd1;
    @(posedge clk); #1;
    d2_w_we = 0;
    for (int i = 0; i < 10; i++) begin
      d2_pool_valid = (i < 4);
      if (i < 4) d2_pool = seq[i]; else d2_pool = '0;
      @(posedge clk); #1;
      if (d2_class_valid) begin n_cls++; cls_cyc = i; cls_val = d2_cls; end
    end
    n_tests++; if (n_cls != 1) begin n_fail++; $display("FAIL ovr_class_pulses: got %0d want 1", n_cls); end
    n_tests++; if (cls_cyc != 6) begin n_fail++; $display("FAIL ovr_class_cycle: got %0d want 6", cls_cyc); end
    n_tests++; if (cls_val !== 2'd1) begin n_fail++; $display("FAIL ovr_class_value: got %0d want 1", cls_val); end
    n_tests++; if (d2_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag_set: got %b want 1", d2_overrun); end
    n_tests++; if (d2_scores !== {48'd0, 48'd0, 48'd7, 48'd0}) begin n_fail++; $display("FAIL ovr_scores: got %h want 0/0/7/0", d2_scores); end
    d2_soft_clr = 1;
    @(posedge clk); #1;
    d2_soft_clr = 0;
    n_tests++; if (d2_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_flag_clear: got %b want 0", d2_overrun); end
    n_tests++; if (d2_cls !== 2'd1) begin n_fail++; $display("FAIL ovr_class_hold: got %0d want 1", d2_cls); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < N_W; a++) m_w[a] = 0;
    for (int o = 0; o < N_OUT; o++) m_b[o] = 0;
    test_reset();
    test_all_ones();
    test_out2_double();
    test_negative();
    test_back_to_back();
    test_soft_clr();
    test_random();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
